// File: rtl/catraca_pkg.sv
// Shared types and defaults for the turnstile controller: FSM state encoding,
// occupancy width and default timing/capacity values.
package catraca_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    LIB_ENT  = 2'd1,
    LIB_SAI  = 2'd2,
    BLOQUEIO = 2'd3
  } estado_t;

  localparam int OCUP_W = 4;

  localparam int TIMEOUT_PADRAO    = 8;
  localparam int BLOQ_PADRAO       = 4;
  localparam int CAPACIDADE_PADRAO = 15;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/controle_catraca_temporizador.sv
// Loadable saturating up-counter; o_fim flags count >= i_limite. One instance
// times both the grant window and the minimum lockout.
module temporizador #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         i_carrega,
  input  logic [W-1:0] i_limite,
  output logic         o_fim
);

  logic [W-1:0] r_cont;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_cont <= '0;
    end else if (i_carrega) begin
      r_cont <= '0;
    end else if (r_cont < i_limite) begin
      r_cont <= r_cont + 1'b1;
    end
  end

  // Saturating at the limit keeps a long lockout from wrapping the count.
  assign o_fim = (r_cont >= i_limite);

endmodule

// File: rtl/controle_catraca.sv
// Turnstile access controller: entry/exit grants, metal-detector lockout and
// optional occupancy counting enabled by the CONTROLE_OCUPACAO_EN macro.
module controle_catraca
  import catraca_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = TIMEOUT_PADRAO,
  parameter int BLOQ_CICLOS    = BLOQ_PADRAO,
  parameter int CAPACIDADE     = CAPACIDADE_PADRAO
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_entrada,
  input  logic              req_saida,
  input  logic              metais,
  input  logic              giro,
  output logic              lib_entrada,
  output logic              lib_saida,
  output logic              alarme,
  output logic [OCUP_W-1:0] ocupacao,
  output logic              cheio
);

  localparam int TMR_W = $clog2(max_int(TIMEOUT_CICLOS, BLOQ_CICLOS) + 1);
  localparam logic [TMR_W-1:0] LIM_TIMEOUT = TMR_W'(TIMEOUT_CICLOS - 1);
  localparam logic [TMR_W-1:0] LIM_BLOQ    = TMR_W'(BLOQ_CICLOS - 1);

  generate
    if (CAPACIDADE < 1 || CAPACIDADE > (1 << OCUP_W) - 1) begin : g_cap_invalida
      $error("CAPACIDADE out of range 1..15");
    end
  endgenerate

  estado_t          r_estado;
  estado_t          w_prox;
  logic             r_ult_saida;
  logic             w_fim;
  logic             w_carrega;
  logic [TMR_W-1:0] w_limite;
  logic             w_ent_ok;
  logic             w_sai_ok;
  logic             w_quer_ent;
  logic             w_quer_sai;

`ifdef CONTROLE_OCUPACAO_EN
  localparam logic [OCUP_W-1:0] CAP_V = OCUP_W'(CAPACIDADE);

  logic [OCUP_W-1:0] r_ocup;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_ocup <= '0;
    end else if (giro && r_estado == LIB_ENT && r_ocup != CAP_V) begin
      r_ocup <= r_ocup + 1'b1;
    end else if (giro && r_estado == LIB_SAI && r_ocup != '0) begin
      r_ocup <= r_ocup - 1'b1;
    end
  end

  assign ocupacao = r_ocup;
  assign cheio    = (r_ocup == CAP_V);
  assign w_ent_ok = !cheio;
  assign w_sai_ok = (r_ocup != '0);
`else
  assign ocupacao = '0;
  assign cheio    = 1'b0;
  assign w_ent_ok = 1'b1;
  assign w_sai_ok = 1'b1;
`endif

  assign w_quer_ent = req_entrada && w_ent_ok;
  assign w_quer_sai = req_saida && w_sai_ok;
  assign w_carrega  = (w_prox != r_estado);
  assign w_limite   = (r_estado == BLOQUEIO) ? LIM_BLOQ : LIM_TIMEOUT;

  temporizador #(.W(TMR_W)) u_temporizador (
    .clock    (clock),
    .resetn   (resetn),
    .i_carrega(w_carrega),
    .i_limite (w_limite),
    .o_fim    (w_fim)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_estado    <= OCIOSO;
      r_ult_saida <= 1'b1;
    end else begin
      r_estado <= w_prox;
      if (giro && r_estado == LIB_ENT) r_ult_saida <= 1'b0;
      else if (giro && r_estado == LIB_SAI) r_ult_saida <= 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first so no path can
  // infer a latch.
  always_comb begin
    w_prox      = r_estado;
    lib_entrada = 1'b0;
    lib_saida   = 1'b0;
    alarme      = 1'b0;
    unique case (r_estado)
      OCIOSO: begin
        if (req_entrada && metais) begin
          w_prox = BLOQUEIO;
        end else if (w_quer_ent && w_quer_sai) begin
          w_prox = r_ult_saida ? LIB_ENT : LIB_SAI;
        end else if (w_quer_ent) begin
          w_prox = LIB_ENT;
        end else if (w_quer_sai) begin
          w_prox = LIB_SAI;
        end
      end
      LIB_ENT: begin
        lib_entrada = 1'b1;
        // A rotation completed alongside metal still counts as a passage.
        if (giro)        w_prox = OCIOSO;
        else if (metais) w_prox = BLOQUEIO;
        else if (w_fim)  w_prox = OCIOSO;
      end
      LIB_SAI: begin
        lib_saida = 1'b1;
        if (giro || w_fim) w_prox = OCIOSO;
      end
      BLOQUEIO: begin
        alarme = 1'b1;
        if (w_fim && !metais) w_prox = OCIOSO;
      end
      default: w_prox = OCIOSO;
    endcase
  end

endmodule

// File: tb/tb_controle_catraca.sv
// Self-checking bench for controle_catraca: table of cycle vectors plus a
// hand-written fill-to-capacity sequence, compared through a scoreboard queue.
module tb_controle_catraca;

`ifdef CONTROLE_OCUPACAO_EN
  localparam bit OCC_EN = 1'b1;
`else
  localparam bit OCC_EN = 1'b0;
`endif

  typedef struct packed {
    logic       le;
    logic       ls;
    logic       al;
    logic [3:0] occ;
    logic       ch;
  } saida_t;

  typedef struct packed {
    logic   rn;
    logic   re;
    logic   rs;
    logic   mt;
    logic   gi;
    saida_t esp;
  } vet_t;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       req_entrada = 1'b0;
  logic       req_saida = 1'b0;
  logic       metais = 1'b0;
  logic       giro = 1'b0;
  logic       lib_entrada;
  logic       lib_saida;
  logic       alarme;
  logic [3:0] ocupacao;
  logic       cheio;

  int     total = 0;
  int     bad = 0;
  saida_t fila[$];
  vet_t   tab[$];

  controle_catraca dut (
    .clock      (clock),
    .resetn     (resetn),
    .req_entrada(req_entrada),
    .req_saida  (req_saida),
    .metais     (metais),
    .giro       (giro),
    .lib_entrada(lib_entrada),
    .lib_saida  (lib_saida),
    .alarme     (alarme),
    .ocupacao   (ocupacao),
    .cheio      (cheio)
  );

  always #5 clock = ~clock;

  // Expected outputs; occupancy and cheio collapse to 0 when counting is off.
  function automatic saida_t s(input logic le, input logic ls, input logic al, input int n);
    saida_t r;
    r.le  = le;
    r.ls  = ls;
    r.al  = al;
    r.occ = OCC_EN ? 4'(n) : 4'd0;
    r.ch  = OCC_EN && (n == 15);
    return r;
  endfunction

  function automatic vet_t v(input logic rn, input logic re, input logic rs,
                             input logic mt, input logic gi, input saida_t e);
    vet_t r;
    r.rn  = rn;
    r.re  = re;
    r.rs  = rs;
    r.mt  = mt;
    r.gi  = gi;
    r.esp = e;
    return r;
  endfunction

  task automatic check(input string nome);
    saida_t got;
    saida_t esp;
    got = '{le: lib_entrada, ls: lib_saida, al: alarme, occ: ocupacao, ch: cheio};
    if (fila.size() == 0) begin
      bad++;
      total++;
      $display("FAIL %s: scoreboard empty", nome);
    end else begin
      esp = fila.pop_front();
      total++;
      if (got !== esp)  begin
        bad++;
        $display("FAIL %s: got le=%b ls=%b al=%b occ=%0d cheio=%b, want le=%b ls=%b al=%b occ=%0d cheio=%b",
                 nome, got.le, got.ls, got.al, got.occ, got.ch,
                 esp.le, esp.ls, esp.al, esp.occ, esp.ch);
      end
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the next edge.
  task automatic passo(input logic rn, input logic re, input logic rs, input logic mt,
                       input logic gi, input saida_t esp, input string nome);
    @(negedge clock);
    resetn      = rn;
    req_entrada = re;
    req_saida   = rs;
    metais      = mt;
    giro        = gi;
    fila.push_back(esp);
    @(posedge clock);
    #1;
    check(nome);
  endtask

  initial begin
    // Reset, then entry grant with rotation three cycles after the grant.
    tab.push_back(v(0,0,0,0,0, s(0,0,0,0)));
    tab.push_back(v(1,1,0,0,0, s(1,0,0,0)));
    tab.push_back(v(1,0,0,0,0, s(1,0,0,0)));
    tab.push_back(v(1,0,0,0,0, s(1,0,0,0)));
    tab.push_back(v(1,0,0,0,1, s(0,0,0,1)));
    tab.push_back(v(1,0,0,0,0, s(0,0,0,1)));
    // Grant without rotation: open for exactly 8 cycles.
    tab.push_back(v(1,1,0,0,0, s(1,0,0,1)));
    for (int i = 0; i < 7; i++) tab.push_back(v(1,0,0,0,0, s(1,0,0,1)));
    tab.push_back(v(1,0,0,0,0, s(0,0,0,1)));
    // Short metal pulse: alarm lasts the 4-cycle minimum.
    tab.push_back(v(1,1,0,1,0, s(0,0,1,1)));
    tab.push_back(v(1,0,0,1,0, s(0,0,1,1)));
    tab.push_back(v(1,0,0,0,0, s(0,0,1,1)));
    tab.push_back(v(1,0,0,0,0, s(0,0,1,1)));
    tab.push_back(v(1,0,0,0,0, s(0,0,0,1)));
    // Metal held 6 cycles: alarm until the first metal-free cycle.
    tab.push_back(v(1,1,0,1,0, s(0,0,1,1)));
    for (int i = 0; i < 5; i++) tab.push_back(v(1,0,0,1,0, s(0,0,1,1)));
    tab.push_back(v(1,0,0,0,0, s(0,0,0,1)));
    // Metal during entry grant revokes it.
    tab.push_back(v(1,1,0,0,0, s(1,0,0,1)));
    tab.push_back(v(1,0,0,1,0, s(0,0,1,1)));
    for (int i = 0; i < 3; i++) tab.push_back(v(1,0,0,0,0, s(0,0,1,1)));
    tab.push_back(v(1,0,0,0,0, s(0,0,0,1)));
    // Metal together with rotation: passage counted.
    tab.push_back(v(1,1,0,0,0, s(1,0,0,1)));
    tab.push_back(v(1,0,0,1,1, s(0,0,0,2)));
    // Rotation while idle is ignored.
    tab.push_back(v(1,0,0,0,1, s(0,0,0,2)));
    // Exit grant ignores metal.
    tab.push_back(v(1,0,1,0,0, s(0,1,0,2)));
    tab.push_back(v(1,0,0,1,0, s(0,1,0,2)));
    tab.push_back(v(1,0,0,1,1, s(0,0,0,1)));
    // Two entries and one exit: occupancy 2, last served = exit.
    tab.push_back(v(1,1,0,0,0, s(1,0,0,1)));
    tab.push_back(v(1,0,0,0,1, s(0,0,0,2)));
    tab.push_back(v(1,1,0,0,0, s(1,0,0,2)));
    tab.push_back(v(1,0,0,0,1, s(0,0,0,3)));
    tab.push_back(v(1,0,1,0,0, s(0,1,0,3)));
    tab.push_back(v(1,0,0,0,1, s(0,0,0,2)));
    // Both requests held: entry, exit, entry, exit.
    tab.push_back(v(1,1,1,0,0, s(1,0,0,2)));
    tab.push_back(v(1,1,1,0,1, s(0,0,0,3)));
    tab.push_back(v(1,1,1,0,0, s(0,1,0,3)));
    tab.push_back(v(1,1,1,0,1, s(0,0,0,2)));
    tab.push_back(v(1,1,1,0,0, s(1,0,0,2)));
    tab.push_back(v(1,1,1,0,1, s(0,0,0,3)));
    tab.push_back(v(1,1,1,0,0, s(0,1,0,3)));
    tab.push_back(v(1,1,1,0,1, s(0,0,0,2)));
    // Reset mid-grant and mid-lockout.
    tab.push_back(v(1,1,0,0,0, s(1,0,0,2)));
    tab.push_back(v(0,0,0,0,0, s(0,0,0,0)));
    tab.push_back(v(1,1,0,0,0, s(1,0,0,0)));
    tab.push_back(v(1,1,0,1,0, s(0,0,1,0)));
    tab.push_back(v(0,0,0,0,0, s(0,0,0,0)));
    tab.push_back(v(1,0,0,0,0, s(0,0,0,0)));
    // Exit at zero occupancy only granted when counting is off.
    tab.push_back(v(1,0,1,0,0, s(0,!OCC_EN,0,0)));
    tab.push_back(v(0,0,0,0,0, s(0,0,0,0)));

    for (int i = 0; i < tab.size(); i++) begin
      passo(tab[i].rn, tab[i].re, tab[i].rs, tab[i].mt, tab[i].gi, tab[i].esp,
            $sformatf("vec%0d", i));
    end

    // Fill to capacity, one entry rotation at a time.
    for (int i = 1; i <= 15; i++) begin
      passo(1,1,0,0,0, s(1,0,0,i-1), $sformatf("fill_grant%0d", i));
      passo(1,0,0,0,1, s(0,0,0,i),   $sformatf("fill_giro%0d", i));
    end
    passo(1,1,0,0,0, s(!OCC_EN,0,0,15), "full_entry_req");
    passo(1,0,0,0,1, s(0,0,0,15),       "full_giro");
    passo(1,0,1,0,0, s(0,1,0,15),       "full_exit_grant");
    passo(1,0,0,0,1, s(0,0,0,14),       "full_exit_giro");

    if (fila.size() != 0) begin
      bad++;
      total++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", fila.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
